fetch_unit: RTL

- Instruction-fetch stage plus IF/ID pipeline register; directly upstream of decode and the hazard logic.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready request channel with a variable-latency response channel.
- Buffers responses in a small queue and presents one instruction per cycle to decode.
- Obeys the hazard unit's IF/ID enable/clear and the EX-stage redirect (taken branch / jump).

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/fetch_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Core-wide definitions shared by fetch and decode:
// instruction width, NOP encoding and the IF/ID bundle.
package fetch_unit_pkg;

    localparam int ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic            valid;
        logic [ILEN-1:0] instr;
        logic [ILEN-1:0] pc;
    } ifid_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs.
// Flush empties it in one cycle; push and pop may coincide.
module fetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        pop_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage write; data needs no reset, occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IF/ID register: owns the PC,
// issues credit-limited requests and drops stale responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            if_dr_en,
    input  logic            if_dr_clear,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [XLEN-1:0]   pc;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop_cnt;
    ifid_t             id_r;

    logic [2*XLEN-1:0] q_wdata;
    logic [2*XLEN-1:0] q_rdata;
    logic [CW-1:0]     qcount;
    logic [CW-1:0]     q_left;
    logic              q_empty;
    logic              q_full;
    logic              q_push;
    logic              q_pop;

    logic              req_fire;
    logic [CW-1:0]     live;
    logic [XLEN-1:0]   rsp_pc;

    // Decode consumes the queue head only when IF/ID loads.
    assign q_pop = if_dr_en && !if_dr_clear
                && !redirect_valid && !q_empty;

    // A slot freed by this cycle's pop can be re-credited now,
    // which keeps the stream at one instruction per cycle.
    assign q_left = qcount - CW'(q_pop);

    assign imem_req_valid = !rst && !redirect_valid
                         && ((inflight + q_left) < CW'(QDEPTH));
    assign imem_req_addr  = pc & ~XLEN'(3);
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Live requests are consecutive words ending just below pc,
    // so the oldest live one sits live*4 bytes behind it.
    assign live   = inflight - drop_cnt;
    assign rsp_pc = pc - (XLEN'(live) << 2);

    assign q_push  = imem_rsp_valid && (drop_cnt == '0)
                  && !redirect_valid;
    assign q_wdata = {rsp_pc, imem_rsp_data};

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (2 * XLEN)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (q_push),
        .push_data (q_wdata),
        .pop       (q_pop),
        .pop_data  (q_rdata),
        .count     (qcount),
        .empty     (q_empty),
        .full      (q_full)
    );

    // PC, in-flight credit and stale-response drop accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_pc & ~XLEN'(3);
            inflight <= inflight - CW'(imem_rsp_valid);
            drop_cnt <= inflight - CW'(imem_rsp_valid);
        end else begin
            if (req_fire) begin
                pc <= pc + XLEN'(4);
            end
            inflight <= inflight + CW'(req_fire)
                      - CW'(imem_rsp_valid);
            if (imem_rsp_valid && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
        end
    end

    // IF/ID register: bubble, then stall, then load from queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_r <= '{valid: 1'b0, instr: NOP, pc: '0};
        end else if (redirect_valid || if_dr_clear) begin
            id_r.valid <= 1'b0;
            id_r.instr <= NOP;
        end else if (if_dr_en) begin
            if (!q_empty) begin
                id_r <= '{valid: 1'b1,
                          instr: q_rdata[XLEN-1:0],
                          pc:    q_rdata[2*XLEN-1:XLEN]};
            end else begin
                id_r.valid <= 1'b0;
            end
        end
    end

    assign id_valid = id_r.valid;
    assign id_instr = id_r.instr;
    assign id_pc    = id_r.pc;

    // The credit rule bounds occupancy; an overflow is a design bug.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst)
        !(q_push && q_full && !q_pop)
    );

    // Memory must never answer a request that was not issued.
    a_rsp_has_req : assert property (
        @(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (inflight != '0)
    );

endmodule
